// File: rtl/z80_block_xfer_ctrl.sv
// Block-transfer sequencer for LDI/LDD/LDIR/LDDR: runs the HL read and DE write bus
// cycles, updates BC/DE/HL/F, iterates repeat forms and returns results to the core.
module z80_block_xfer_ctrl (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [15:0] bc_i,
    input  logic [15:0] de_i,
    input  logic [15:0] hl_i,
    input  logic [7:0]  f_i,
    input  logic [15:0] ip_i,
    input  logic        int_req_i,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bc_o,
    output logic [15:0] de_o,
    output logic [15:0] hl_o,
    output logic [7:0]  f_o,
    output logic [15:0] ip_o
);

    localparam int unsigned FlagH  = 4;
    localparam int unsigned FlagPv = 2;
    localparam int unsigned FlagN  = 1;
    localparam logic [7:0] ClrMask = ~((8'd1 << FlagH) | (8'd1 << FlagPv) | (8'd1 << FlagN));
    localparam logic [7:0] PvMask  = 8'd1 << FlagPv;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StUpdate,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] bc_q, bc_d, de_q, de_d, hl_q, hl_d, ip_q, ip_d;
    logic [7:0]  f_q, f_d;
    logic        int_q, int_d;
    logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [15:0] bc_out_q, bc_out_d, de_out_q, de_out_d, hl_out_q, hl_out_d;
    logic [15:0] ip_out_q, ip_out_d;
    logic [7:0]  f_out_q, f_out_d;

    logic [15:0] bc_nxt, de_nxt, hl_nxt;
    logic [7:0]  f_nxt;

    always_comb begin
        bc_nxt = bc_q - 16'd1;
        hl_nxt = op_q[0] ? (hl_q - 16'd1) : (hl_q + 16'd1);
        de_nxt = op_q[0] ? (de_q - 16'd1) : (de_q + 16'd1);
        f_nxt  = (f_q & ClrMask) | ((bc_nxt != 16'd0) ? PvMask : 8'd0);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        bc_d        = bc_q;
        de_d        = de_q;
        hl_d        = hl_q;
        f_d         = f_q;
        ip_d        = ip_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bc_out_d    = bc_out_q;
        de_out_d    = de_out_q;
        hl_out_d    = hl_out_q;
        f_out_d     = f_out_q;
        ip_out_d    = ip_out_q;
        // A request arriving in UPDATE still counts for this boundary.
        int_d       = int_q | (int_req_i &&
                      (state_q == StRead || state_q == StWrite || state_q == StUpdate));

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d       = op_i;
                    bc_d       = bc_i;
                    de_d       = de_i;
                    hl_d       = hl_i;
                    f_d        = f_i;
                    ip_d       = ip_i;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = hl_i;
                    busy_d     = 1'b1;
                    state_d    = StRead;
                end
            end
            StRead: begin
                if (mem_ready_i) begin
                    mem_wdata_d = mem_rdata_i;
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = de_q;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (mem_ready_i) begin
                    mem_wr_d = 1'b0;
                    state_d  = StUpdate;
                end
            end
            StUpdate: begin
                bc_d = bc_nxt;
                de_d = de_nxt;
                hl_d = hl_nxt;
                f_d  = f_nxt;
                if (op_q[1] && (bc_nxt != 16'd0) && !int_d) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = hl_nxt;
                    state_d    = StRead;
                end else begin
                    int_d    = 1'b0;
                    done_d   = 1'b1;
                    bc_out_d = bc_nxt;
                    de_out_d = de_nxt;
                    hl_out_d = hl_nxt;
                    f_out_d  = f_nxt;
                    // Interrupted repeat forms point back at the ED prefix.
                    ip_out_d = (!op_q[1] || (bc_nxt == 16'd0)) ? (ip_q + 16'd2) : ip_q;
                    state_d  = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            op_q        <= 2'd0;
            bc_q        <= 16'd0;
            de_q        <= 16'd0;
            hl_q        <= 16'd0;
            f_q         <= 8'd0;
            ip_q        <= 16'd0;
            int_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bc_out_q    <= 16'd0;
            de_out_q    <= 16'd0;
            hl_out_q    <= 16'd0;
            f_out_q     <= 8'd0;
            ip_out_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            bc_q        <= bc_d;
            de_q        <= de_d;
            hl_q        <= hl_d;
            f_q         <= f_d;
            ip_q        <= ip_d;
            int_q       <= int_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bc_out_q    <= bc_out_d;
            de_out_q    <= de_out_d;
            hl_out_q    <= hl_out_d;
            f_out_q     <= f_out_d;
            ip_out_q    <= ip_out_d;
        end
    end

    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign bc_o        = bc_out_q;
    assign de_o        = de_out_q;
    assign hl_o        = hl_out_q;
    assign f_o         = f_out_q;
    assign ip_o        = ip_out_q;

endmodule

// File: tb/tb_z80_block_xfer_ctrl.sv
// Scoreboard bench for z80_block_xfer_ctrl: expected writes and results are queued by the
// stimulus and popped by a negedge monitor whenever the DUT writes or pulses done.
module tb_z80_block_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] bc_in = 16'd0, de_in = 16'd0, hl_in = 16'd0, ip_in = 16'd0;
    logic [7:0]  f_in = 8'd0;
    logic        int_req = 1'b0;
    logic        mem_rd, mem_wr, mem_ready = 1'b1, busy, done;
    logic [15:0] mem_addr, bc_out, de_out, hl_out, ip_out;
    logic [7:0]  mem_wdata, mem_rdata, f_out;

    logic [7:0] mem [0:65535];
    assign mem_rdata = mem[mem_addr];

    z80_block_xfer_ctrl dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
        .bc_i(bc_in), .de_i(de_in), .hl_i(hl_in), .f_i(f_in), .ip_i(ip_in),
        .int_req_i(int_req), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready), .busy_o(busy), .done_o(done),
        .bc_o(bc_out), .de_o(de_out), .hl_o(hl_out), .f_o(f_out), .ip_o(ip_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bc, de, hl;
        logic [7:0]  f;
        logic [15:0] ip;
        int          cyc;
    } res_t;
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    res_t res_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rd_wait = 0, wr_wait = 0, int_arm = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus agent: wait-state insertion and interrupt injection after N observed writes.
    always @(posedge clk) begin
        #1;
        int_req = 1'b0;
        if (mem_rd && rd_wait > 0) begin
            mem_ready = 1'b0;
            rd_wait--;
        end else if (mem_wr && wr_wait > 0) begin
            mem_ready = 1'b0;
            wr_wait--;
        end else begin
            mem_ready = 1'b1;
        end
        if (int_arm > 0 && mem_wr) begin
            int_arm--;
            if (int_arm == 0) int_req = 1'b1;
        end
    end

    logic        hold_chk = 1'b0, prev_rd, prev_wr;
    logic [15:0] prev_addr;

    always @(negedge clk) begin
        if (reset) begin
            hold_chk = 1'b0;
        end else begin
            if (mem_rd && mem_wr) chk("rd_wr_exclusive", 32'd1, 32'd0);
            if (hold_chk) begin
                chk("hold_rd", {31'd0, mem_rd}, {31'd0, prev_rd});
                chk("hold_wr", {31'd0, mem_wr}, {31'd0, prev_wr});
                chk("hold_addr", {16'd0, mem_addr}, {16'd0, prev_addr});
            end
            hold_chk  = (mem_rd || mem_wr) && !mem_ready;
            prev_rd   = mem_rd;
            prev_wr   = mem_wr;
            prev_addr = mem_addr;
            if (mem_wr && mem_ready) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {16'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    automatic wr_t w = wr_q.pop_front();
                    chk("wr_addr", {16'd0, mem_addr}, {16'd0, w.addr});
                    chk("wr_data", {24'd0, mem_wdata}, {24'd0, w.data});
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    automatic res_t r = res_q.pop_front();
                    chk("bc_out", {16'd0, bc_out}, {16'd0, r.bc});
                    chk("de_out", {16'd0, de_out}, {16'd0, r.de});
                    chk("hl_out", {16'd0, hl_out}, {16'd0, r.hl});
                    chk("f_out", {24'd0, f_out}, {24'd0, r.f});
                    chk("ip_out", {16'd0, ip_out}, {16'd0, r.ip});
                    chk("done_cycle", cyc, r.cyc);
                end
            end
        end
    end

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] b, d, h, input logic [7:0] fl,
                          input logic [15:0] ipv, input logic [15:0] eb, ed, eh,
                          input logic [7:0] ef, input logic [15:0] eip, input int lat,
                          input bit spurious);
        @(posedge clk);
        #1;
        op = o; bc_in = b; de_in = d; hl_in = h; f_in = fl; ip_in = ipv;
        start = 1'b1;
        res_q.push_back('{bc: eb, de: ed, hl: eh, f: ef, ip: eip, cyc: cyc + lat});
        @(posedge clk);
        #1;
        start = 1'b0;
        if (spurious) begin
            @(posedge clk);
            #1;
            op = 2'b00; bc_in = 16'h1234; de_in = 16'hAAAA; hl_in = 16'h5555; ip_in = 16'hBEEF;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        mem[16'h1000] = 8'h10; mem[16'h1001] = 8'h20; mem[16'h1002] = 8'h30;
        mem[16'h0000] = 8'hA5; mem[16'h1200] = 8'h77;
        mem[16'h1300] = 8'h11; mem[16'h1301] = 8'h22; mem[16'h1400] = 8'h3C;
        mem[16'h1500] = 8'h99; mem[16'h1600] = 8'h44;
        mem[16'h0005] = 8'hE1; mem[16'h0004] = 8'hE2;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("rst_addr_wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
        chk("rst_bc_de", {bc_out, de_out}, 32'd0);
        chk("rst_hl_ip", {hl_out, ip_out}, 32'd0);
        chk("rst_f", {24'd0, f_out}, 32'd0);

        // LDI single step (1000 holds 10 here)
        wr_q.push_back('{addr: 16'h2000, data: 8'h10});
        run_op(2'b00, 16'h0002, 16'h2000, 16'h1000, 8'hFF, 16'h0100,
               16'h0001, 16'h2001, 16'h1001, 8'hED, 16'h0102, 4, 0);
        // LDD to zero with address wrap
        wr_q.push_back('{addr: 16'h0000, data: 8'hA5});
        run_op(2'b01, 16'h0001, 16'h0000, 16'h0000, 8'h04, 16'h0200,
               16'h0000, 16'hFFFF, 16'hFFFF, 8'h00, 16'h0202, 4, 0);
        // LDIR three bytes
        wr_q.push_back('{addr: 16'h2000, data: 8'h10});
        wr_q.push_back('{addr: 16'h2001, data: 8'h20});
        wr_q.push_back('{addr: 16'h2002, data: 8'h30});
        run_op(2'b10, 16'h0003, 16'h2000, 16'h1000, 8'h00, 16'h0300,
               16'h0000, 16'h2003, 16'h1003, 8'h00, 16'h0302, 10, 0);
        // LDIR interrupted during the first write
        int_arm = 1;
        wr_q.push_back('{addr: 16'h4000, data: 8'h77});
        run_op(2'b10, 16'h0005, 16'h4000, 16'h1200, 8'h00, 16'h0400,
               16'h0004, 16'h4001, 16'h1201, 8'h04, 16'h0400, 4, 0);
        // Latch must be clear: a following LDIR runs to completion
        wr_q.push_back('{addr: 16'h4100, data: 8'h11});
        wr_q.push_back('{addr: 16'h4101, data: 8'h22});
        run_op(2'b10, 16'h0002, 16'h4100, 16'h1300, 8'h00, 16'h0500,
               16'h0000, 16'h4102, 16'h1302, 8'h00, 16'h0502, 7, 0);
        // Wait states: 3 in READ, 2 in WRITE
        rd_wait = 3;
        wr_wait = 2;
        wr_q.push_back('{addr: 16'h5000, data: 8'h3C});
        run_op(2'b00, 16'h0010, 16'h5000, 16'h1400, 8'h00, 16'h0600,
               16'h000F, 16'h5001, 16'h1401, 8'h04, 16'h0602, 9, 0);
        // LDD with BC=0 wraps to FFFF and sets PV
        wr_q.push_back('{addr: 16'h6000, data: 8'h99});
        run_op(2'b01, 16'h0000, 16'h6000, 16'h1500, 8'h00, 16'h0700,
               16'hFFFF, 16'h5FFF, 16'h14FF, 8'h04, 16'h0702, 4, 0);
        // LDDR with BC=0 loops; spurious start ignored; interrupt after second write
        int_arm = 2;
        wr_q.push_back('{addr: 16'h8005, data: 8'hE1});
        wr_q.push_back('{addr: 16'h8004, data: 8'hE2});
        run_op(2'b11, 16'h0000, 16'h8005, 16'h0005, 8'hFF, 16'h0900,
               16'hFFFE, 16'h8003, 16'h0003, 8'hED, 16'h0900, 7, 1);

        // Reset while stalled in WRITE: no write completes, no done
        wr_wait = 1000;
        @(posedge clk);
        #1;
        op = 2'b00; bc_in = 16'h0001; de_in = 16'h7000; hl_in = 16'h1600; ip_in = 16'h0800;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !mem_wr; i++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_write", {31'd0, mem_wr}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_wait = 0;
        @(negedge clk);
        chk("mid_rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("mid_rst_out", {bc_out, ip_out}, 32'd0);
        repeat (10) @(posedge clk);

        chk("wr_q_empty", wr_q.size(), 32'd0);
        chk("res_q_empty", res_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
